// File: rtl/wash_pkg.sv
// Shared types for the wash sequencer: state encoding, fault codes and the
// rinse-count width helper.
package wash_pkg;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_LOCK         = 4'd1,
    S_FILL         = 4'd2,
    S_AGITATE      = 4'd3,
    S_DRAIN        = 4'd4,
    S_SPIN         = 4'd5,
    S_FINAL_DRAIN  = 4'd6,
    S_CANCEL_DRAIN = 4'd7,
    S_DONE         = 4'd8,
    S_PAUSED       = 4'd9,
    S_FAULT        = 4'd10
  } wash_state_e;

  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_FILL  = 3'd1;
  localparam logic [2:0] FC_DRAIN = 3'd2;
  localparam logic [2:0] FC_DOOR  = 3'd3;
  localparam logic [2:0] FC_LOCK  = 3'd4;

  // Bits needed to hold 0..max_rinse; never less than one bit.
  function automatic int rw_of(input int max_rinse);
    return (max_rinse < 1) ? 1 : $clog2(max_rinse + 1);
  endfunction

endpackage

// File: rtl/wash_seq_ctrl_if.sv
// Panel/sensor/actuator bundle between the program logic and the wash sequencer.
interface wash_seq_ctrl_if #(
  parameter int RW = 2
);
  import wash_pkg::*;

  // Door-lock handshake: door_lock is a level request held for the whole
  // locked phase; lock_ack is a level sampled on each rising edge while in
  // LOCK, and the first edge that sees it high completes the handshake.
  logic          start;
  logic [RW-1:0] rinses;
  logic          spin_en;
  logic          pause;
  logic          cancel;
  logic          clear_fault;
  logic          door_open;
  logic          lock_ack;
  logic          water_full;
  logic          drained;
  logic          dry_sensor;

  logic          water_fill;
  logic          motor_wash;
  logic          motor_spin;
  logic          drain;
  logic          door_lock;
  logic          busy;
  logic          done;
  logic          fault;
  logic [2:0]    fault_code;
  logic [RW-1:0] rinse_left;
  wash_state_e   state_dbg;

  modport master (
    output start, rinses, spin_en, pause, cancel, clear_fault,
    output door_open, lock_ack, water_full, drained, dry_sensor,
    input  water_fill, motor_wash, motor_spin, drain, door_lock,
    input  busy, done, fault, fault_code, rinse_left, state_dbg
  );

  modport slave (
    input  start, rinses, spin_en, pause, cancel, clear_fault,
    input  door_open, lock_ack, water_full, drained, dry_sensor,
    output water_fill, motor_wash, motor_spin, drain, door_lock,
    output busy, done, fault, fault_code, rinse_left, state_dbg
  );

endinterface

// File: rtl/phase_timer.sv
// Shared phase timer: cleared on phase entry, frozen while held.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          hold,
  output logic [TW-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!hold) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/wash_seq_ctrl.sv
// Programmable wash-cycle sequencer: lock, fill/agitate/drain per rinse,
// optional spin, pause with timer hold, watchdogs and a drain-to-safe cancel.
module wash_seq_ctrl
  import wash_pkg::*;
#(
  parameter int TW          = 8,
  parameter int T_WASH      = 10,
  parameter int T_RINSE     = 6,
  parameter int T_SPIN_MAX  = 12,
  parameter int T_FILL_MAX  = 20,
  parameter int T_DRAIN_MAX = 15,
  parameter int T_LOCK_MAX  = 4,
  parameter int MAX_RINSE   = 3
) (
  input logic           clk,
  input logic           rstn,
  wash_seq_ctrl_if.slave bus
);

  localparam int RW = rw_of(MAX_RINSE);

  wash_state_e   state, state_n;
  wash_state_e   saved, saved_n;
  logic [RW-1:0] rinse_q, rinse_n;
  logic          spin_q, spin_n;
  logic          first_q, first_n;
  logic [2:0]    code_q, code_n;

  logic [TW-1:0] count;
  logic          tmr_clr;
  logic          tmr_hold;
  logic [31:0]   rinses_w;
  logic [RW-1:0] rinses_sat;

  // ">=" rather than "==" so a pause taken on the expiring cycle, which
  // resumes one count past T-1, still ends the phase.
  function automatic logic expired(input logic [TW-1:0] cnt, input int t);
    return int'(cnt) >= (t - 1);
  endfunction

  assign rinses_w   = 32'(bus.rinses);
  assign rinses_sat = (rinses_w > 32'(MAX_RINSE)) ? RW'(MAX_RINSE) : bus.rinses;

  phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (tmr_clr),
    .hold  (tmr_hold),
    .count (count)
  );

  // Entering PAUSED and returning to the saved phase keep the count.
  assign tmr_hold = (state == S_PAUSED);
  assign tmr_clr  = (state_n != state) && (state_n != S_PAUSED) &&
                    !((state == S_PAUSED) && (state_n == saved));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      saved   <= S_IDLE;
      rinse_q <= '0;
      spin_q  <= 1'b0;
      first_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state   <= state_n;
      saved   <= saved_n;
      rinse_q <= rinse_n;
      spin_q  <= spin_n;
      first_q <= first_n;
      code_q  <= code_n;
    end
  end

  always_comb begin
    state_n = state;
    saved_n = saved;
    rinse_n = rinse_q;
    spin_n  = spin_q;
    first_n = first_q;
    code_n  = code_q;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.door_open) begin
          state_n = S_LOCK;
          rinse_n = rinses_sat;
          spin_n  = bus.spin_en;
          first_n = 1'b1;
        end
      end

      S_LOCK: begin
        if (bus.door_open || bus.cancel) begin
          state_n = S_IDLE;
        end else if (bus.lock_ack) begin
          state_n = S_FILL;
        end else if (expired(count, T_LOCK_MAX)) begin
          state_n = S_FAULT;
          code_n  = FC_LOCK;
        end
      end

      S_FILL, S_AGITATE, S_DRAIN, S_SPIN, S_FINAL_DRAIN, S_PAUSED: begin
        if (bus.door_open) begin
          state_n = S_FAULT;
          code_n  = FC_DOOR;
        end else if (bus.cancel) begin
          state_n = S_CANCEL_DRAIN;
        end else if (state == S_PAUSED) begin
          if (!bus.pause) state_n = saved;
        end else if (bus.pause && (state != S_FINAL_DRAIN)) begin
          state_n = S_PAUSED;
          saved_n = state;
        end else begin
          case (state)
            S_FILL: begin
              if (bus.water_full) begin
                state_n = S_AGITATE;
              end else if (expired(count, T_FILL_MAX)) begin
                state_n = S_FAULT;
                code_n  = FC_FILL;
              end
            end
            S_AGITATE: begin
              if (expired(count, first_q ? T_WASH : T_RINSE)) state_n = S_DRAIN;
            end
            S_DRAIN: begin
              if (bus.drained) begin
                if (rinse_q != '0) begin
                  state_n = S_FILL;
                  rinse_n = rinse_q - RW'(1);
                  first_n = 1'b0;
                end else begin
                  state_n = spin_q ? S_SPIN : S_DONE;
                end
              end else if (expired(count, T_DRAIN_MAX)) begin
                state_n = S_FAULT;
                code_n  = FC_DRAIN;
              end
            end
            S_SPIN: begin
              if (bus.dry_sensor || expired(count, T_SPIN_MAX)) state_n = S_FINAL_DRAIN;
            end
            S_FINAL_DRAIN: begin
              if (bus.drained) begin
                state_n = S_DONE;
              end else if (expired(count, T_DRAIN_MAX)) begin
                state_n = S_FAULT;
                code_n  = FC_DRAIN;
              end
            end
            default: begin
              state_n = state;
            end
          endcase
        end
      end

      S_CANCEL_DRAIN: begin
        if (bus.drained) begin
          state_n = S_IDLE;
        end else if (expired(count, T_DRAIN_MAX)) begin
          state_n = S_FAULT;
          code_n  = FC_DRAIN;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      S_FAULT: begin
        if (bus.clear_fault && !bus.door_open) begin
          state_n = S_IDLE;
          code_n  = FC_NONE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.door_lock  = state inside {S_LOCK, S_FILL, S_AGITATE, S_DRAIN, S_SPIN,
                                        S_FINAL_DRAIN, S_CANCEL_DRAIN, S_PAUSED};
  assign bus.water_fill = (state == S_FILL);
  assign bus.motor_wash = (state == S_AGITATE);
  assign bus.motor_spin = (state == S_SPIN);
  assign bus.drain      = state inside {S_DRAIN, S_SPIN, S_FINAL_DRAIN, S_CANCEL_DRAIN};
  assign bus.busy       = (state != S_IDLE) && (state != S_FAULT);
  assign bus.done       = (state == S_DONE);
  assign bus.fault      = (state == S_FAULT);
  assign bus.fault_code = code_q;
  assign bus.rinse_left = rinse_q;
  assign bus.state_dbg  = state;

endmodule
